// File: rtl/wb_host_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_host_initiator                                                 |
// | Brief  : Single-outstanding Wishbone classic initiator. Accepts commands   |
// |          on a valid/ready stream, runs one bus cycle per command and       |
// |          returns the result on a valid/ready response stream.             |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   TO_BITS      width of the watchdog counter; a cycle is abandoned after   |
// |                2^TO_BITS-1 wait cycles without ack/err                     |
// | Build option                                                               |
// |   WB_HOST_TIMEOUT_EN  when defined, enables the watchdog. When undefined,  |
// |                       a bus cycle waits forever and rsp_timeout is 0.      |
// | Ports                                                                      |
// |   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset         |
// |   cmd_valid/cmd_ready        command handshake                             |
// |   cmd_we/adr/dat/sel         command fields                                |
// |   rsp_valid/rsp_ready        response handshake                            |
// |   rsp_dat/rsp_err/rsp_timeout response fields                              |
// |   wbm_cyc_o..wbm_dat_o       Wishbone initiator outputs                    |
// |   wbm_dat_i/ack_i/err_i      Wishbone slave returns                        |
// +----------------------------------------------------------------------------+
module wb_host_initiator #(
  parameter int unsigned TO_BITS = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        w_accept;
  logic        w_slave_term;
  logic        w_to_hit;
  logic        w_term;

  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_rsp_dat;
  logic        r_rsp_err;

  if (TO_BITS < 1 || TO_BITS > 31) begin : g_to_bits_check
    $error("wb_host_initiator: TO_BITS must be in 1..31");
  end

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_slave_term = wbm_ack_i || wbm_err_i;
  assign w_term       = w_slave_term || w_to_hit;

`ifdef WB_HOST_TIMEOUT_EN
  logic [TO_BITS-1:0] r_to_cnt;
  logic               r_rsp_to;

  // A slave response on the final count edge takes priority over the timeout.
  assign w_to_hit = (r_state == S_BUS) && (r_to_cnt == {TO_BITS{1'b1}}) && !w_slave_term;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_BUS) && !w_slave_term) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rsp_to <= 1'b0;
    end else if ((r_state == S_BUS) && w_term) begin
      r_rsp_to <= w_to_hit;
    end
  end

  assign rsp_timeout = r_rsp_to;
`else
  assign w_to_hit    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_nxt = S_BUS;
      S_BUS:   if (w_term)    w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command capture; fields are left untouched while idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we  <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (w_accept) begin
      r_we  <= cmd_we;
      r_sel <= cmd_sel;
      r_adr <= cmd_adr;
      r_dat <= cmd_dat;
    end
  end

  // Response capture at the terminating edge. Err outranks ack; read data is
  // only returned for an acked read.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else if ((r_state == S_BUS) && w_term) begin
      if (wbm_err_i) begin
        r_rsp_dat <= '0;
        r_rsp_err <= 1'b1;
      end else if (wbm_ack_i) begin
        r_rsp_dat <= r_we ? 32'h0 : wbm_dat_i;
        r_rsp_err <= 1'b0;
      end else begin
        r_rsp_dat <= 32'hFFFF_FFFF;
        r_rsp_err <= 1'b1;
      end
    end
  end

  // Handshake and strobe outputs decode the state directly so that an
  // asynchronous reset drops them without waiting for a clock edge.
  assign cmd_ready = (r_state == S_IDLE);
  assign wbm_cyc_o = (r_state == S_BUS);
  assign wbm_stb_o = (r_state == S_BUS);
  assign rsp_valid = (r_state == S_RESP);

  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_wb_host_initiator                                              |
// | Brief  : Self-checking bench for wb_host_initiator. A behavioural slave    |
// |          answers bus cycles; expected responses are queued when commands   |
// |          are issued and compared when the response handshake completes.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_wb_host_initiator;

  localparam int unsigned c_TO_BITS = 4;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  wb_host_initiator #(.TO_BITS(c_TO_BITS)) u_dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_adr     (cmd_adr),
    .cmd_dat     (cmd_dat),
    .cmd_sel     (cmd_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_dat     (rsp_dat),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural slave: answers after slv_wait wait states.
  logic        slv_silent;
  logic        slv_err_only;
  logic        slv_both;
  int          slv_wait;
  logic [31:0] slv_rdata;
  int          slv_wcnt;

  assign wbm_dat_i = slv_rdata;
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !slv_silent && !slv_err_only &&
                     (slv_wcnt == slv_wait);
  assign wbm_err_i = wbm_cyc_o && wbm_stb_o && !slv_silent && (slv_err_only || slv_both) &&
                     (slv_wcnt == slv_wait);

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)        slv_wcnt <= 0;
    else if (!wbm_cyc_o) slv_wcnt <= 0;
    else                 slv_wcnt <= slv_wcnt + 1;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
    int          len;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk_exp(input logic [31:0] dat, input logic err,
                                  input logic to, input int len);
    exp_t e;
    e.dat = dat; e.err = err; e.to = to; e.len = len;
    return e;
  endfunction

  // Response monitor: a handshake visible at the falling edge completes at
  // the following rising edge.
  int cyc_len = 0;
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (wb_rst_i) begin
      cyc_len = 0;
    end else begin
      if (wbm_cyc_o) cyc_len++;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("rsp_dat", rsp_dat, e.dat);
          check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check_val("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
          check_val("cyc_len", cyc_len, e.len);
        end
        cyc_len = 0;
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    int guard;
    guard     = 0;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 200) begin
      @(posedge wb_clk_i); #1;
      guard++;
    end
    if (!cmd_ready) check_val("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || rsp_valid || !cmd_ready) && guard < 300) begin
      @(posedge wb_clk_i); #1;
      guard++;
    end
    check_val("drain_done", {31'd0, (sb.size() == 0 && cmd_ready)}, 32'd1);
  endtask

  task automatic set_slave(input int waits, input logic [31:0] rdata,
                           input logic err_only, input logic both, input logic silent);
    slv_wait     = waits;
    slv_rdata    = rdata;
    slv_err_only = err_only;
    slv_both     = both;
    slv_silent   = silent;
  endtask

  initial begin
    int cyc_hi;
    int guard;
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b1;
    set_slave(0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;

    // Reset pulse while idle, then reset values.
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_flags", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    check_val("rst_rsp_dat", rsp_dat, 32'd0);
    check_val("rst_wbm_ctl", {28'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, 1'b0}, 32'd0);
    check_val("rst_wbm_sel", {28'd0, wbm_sel_o}, 32'd0);
    check_val("rst_wbm_adr", wbm_adr_o, 32'd0);
    check_val("rst_wbm_dat", wbm_dat_o, 32'd0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    // Zero-wait read with edge-accurate timing.
    set_slave(0, 32'hA5A5_1234, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk_exp(32'hA5A5_1234, 1'b0, 1'b0, 1));
    send(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    check_val("rd0_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    check_val("rd0_adr", wbm_adr_o, 32'h3000_0004);
    check_val("rd0_we", {31'd0, wbm_we_o}, 32'd0);
    check_val("rd0_cmd_ready_bus", {31'd0, cmd_ready}, 32'd0);
    @(posedge wb_clk_i); #1;
    check_val("rd0_rsp_valid_n1", {31'd0, rsp_valid}, 32'd1);
    check_val("rd0_cyc_dropped", {31'd0, wbm_cyc_o}, 32'd0);
    @(posedge wb_clk_i); #1;
    check_val("rd0_idle_n2", {31'd0, cmd_ready}, 32'd1);
    drain();

    // Write with three wait states.
    set_slave(3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk_exp(32'h0, 1'b0, 1'b0, 4));
    send(1'b1, 32'h3000_0000, 32'h0000_00FF, 4'b0001);
    @(posedge wb_clk_i); #1;
    check_val("wr_cyc_hold", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    check_val("wr_adr", wbm_adr_o, 32'h3000_0000);
    check_val("wr_dat", wbm_dat_o, 32'h0000_00FF);
    check_val("wr_sel_we", {27'd0, wbm_sel_o, wbm_we_o}, {27'd0, 4'b0001, 1'b1});
    drain();
    check_val("idle_adr_kept", wbm_adr_o, 32'h3000_0000);

    // Ack and err together on a read: err wins, data zeroed.
    set_slave(0, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
    sb.push_back(mk_exp(32'h0, 1'b1, 1'b0, 1));
    send(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    drain();

    // Err only, with two wait states.
    set_slave(2, 32'h3333_4444, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(32'h0, 1'b1, 1'b0, 3));
    send(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    drain();

    // Back-pressure: response held for 10 cycles, no new bus cycle.
    set_slave(1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    sb.push_back(mk_exp(32'h1234_5678, 1'b0, 1'b0, 2));
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(posedge wb_clk_i); #1;
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_adr   = 32'h3000_0020;
    for (int i = 0; i < 10; i++) begin
      check_val("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("hold_rsp_dat", rsp_dat, 32'h1234_5678);
      check_val("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check_val("hold_no_cyc", {31'd0, wbm_cyc_o}, 32'd0);
      @(posedge wb_clk_i); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

`ifdef WB_HOST_TIMEOUT_EN
    // Silent slave: watchdog ends the cycle after 15 wait cycles.
    set_slave(0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1);
    sb.push_back(mk_exp(32'hFFFF_FFFF, 1'b1, 1'b1, 16));
    send(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    drain();
    // Ack on the final count edge beats the timeout.
    set_slave(15, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk_exp(32'h0F0F_0F0F, 1'b0, 1'b0, 16));
    send(1'b0, 32'h3000_0018, 32'h0, 4'hF);
    drain();
    // Leave a cycle hanging for the reset check below.
    set_slave(0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 32'h3000_001C, 32'h0, 4'hF);
    repeat (3) @(posedge wb_clk_i);
    #1;
`else
    // Silent slave: without the watchdog the cycle never ends.
    set_slave(0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 32'h3000_001C, 32'h0, 4'hF);
    cyc_hi = 0;
    for (int i = 0; i < 120; i++) begin
      if (wbm_cyc_o) cyc_hi++;
      @(posedge wb_clk_i); #1;
    end
    check_val("no_to_cyc_held", cyc_hi, 120);
`endif

    // Asynchronous reset in BUS drops the cycle without a clock edge.
    check_val("pre_rst_in_bus", {31'd0, wbm_cyc_o}, 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check_val("async_rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check_val("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    slv_silent = 1'b0;
    repeat (6) @(posedge wb_clk_i);
    #1;
    check_val("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check_val("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
